// File: rtl/room_controller.sv
// Room sequencer for a 4x4 maze: detects the player leaving through a room edge,
// blanks the display for a few frames, then loads the neighbour room and respawns the player.
module room_controller #(
  parameter logic [3:0] START_ROOM   = 4'd5,
  parameter int         BLANK_FRAMES = 2
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       player_valid,
  input  logic [9:0] player_x,
  input  logic [8:0] player_y,
  output logic [3:0] room_id,
  output logic [7:0] wall_color,
  output logic       room_valid,
  output logic       player_load,
  output logic [9:0] player_new_x,
  output logic [8:0] player_new_y
);

  typedef enum logic [1:0] {PLAY, BLANK, LOAD} state_e;
  typedef enum logic [1:0] {DIR_N, DIR_S, DIR_W, DIR_E} dir_e;

  localparam logic [3:0] LAST_FRAME = 4'(BLANK_FRAMES - 1);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d, exit_dir;
  logic [3:0] room_q, room_d, cnt_q, cnt_d;
  logic [7:0] wall_q, wall_d;
  logic       valid_q, valid_d, load_q, load_d, exit_ok;
  logic [9:0] new_x_q, new_x_d, samp_x_q, samp_x_d;
  logic [8:0] new_y_q, new_y_d, samp_y_q, samp_y_d;
  logic [1:0] row, col;
  logic       go_n, go_s, go_w, go_e;
  logic [3:0] nbr_room;

  assign row = room_q[3:2];
  assign col = room_q[1:0];

  // An edge only counts as an exit when a neighbour exists on that side (no wrap).
  assign go_n = (player_y <= 9'd8)    && (row != 2'd0);
  assign go_s = (player_y >= 9'd471)  && (row != 2'd3);
  assign go_w = (player_x <= 10'd8)   && (col != 2'd0);
  assign go_e = (player_x >= 10'd631) && (col != 2'd3);
  assign exit_ok = go_n | go_s | go_w | go_e;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    exit_dir = DIR_E;
    if (go_n)      exit_dir = DIR_N;
    else if (go_s) exit_dir = DIR_S;
    else if (go_w) exit_dir = DIR_W;

    nbr_room = room_q;
    case (dir_q)
      DIR_N:   nbr_room = {row - 2'd1, col};
      DIR_S:   nbr_room = {row + 2'd1, col};
      DIR_W:   nbr_room = {row, col - 2'd1};
      default: nbr_room = {row, col + 2'd1};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    room_d   = room_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    load_d   = 1'b0;
    new_x_d  = new_x_q;
    new_y_d  = new_y_q;
    samp_x_d = samp_x_q;
    samp_y_d = samp_y_q;

    case (state_q)
      PLAY: begin
        if (frame_start && player_valid && exit_ok) begin
          state_d  = BLANK;
          valid_d  = 1'b0;
          cnt_d    = 4'd0;
          dir_d    = exit_dir;
          samp_x_d = player_x;
          samp_y_d = player_y;
        end
      end
      BLANK: begin
        if (frame_start) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_FRAME) begin
            state_d = LOAD;
            room_d  = nbr_room;
            load_d  = 1'b1;
            new_x_d = samp_x_q;
            new_y_d = samp_y_q;
            case (dir_q)
              DIR_N:   new_y_d = 9'd460;
              DIR_S:   new_y_d = 9'd12;
              DIR_W:   new_x_d = 10'd620;
              default: new_x_d = 10'd12;
            endcase
          end
        end
      end
      LOAD: begin
        state_d = PLAY;
        valid_d = 1'b1;
        dir_d   = DIR_N;
      end
      default: state_d = PLAY;
    endcase

    wall_d = {room_d, 4'b1100};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PLAY;
      dir_q    <= DIR_N;
      room_q   <= START_ROOM;
      wall_q   <= {START_ROOM, 4'b1100};
      cnt_q    <= 4'd0;
      valid_q  <= 1'b1;
      load_q   <= 1'b0;
      new_x_q  <= 10'd0;
      new_y_q  <= 9'd0;
      samp_x_q <= 10'd0;
      samp_y_q <= 9'd0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      room_q   <= room_d;
      wall_q   <= wall_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      load_q   <= load_d;
      new_x_q  <= new_x_d;
      new_y_q  <= new_y_d;
      samp_x_q <= samp_x_d;
      samp_y_q <= samp_y_d;
    end
  end

  assign room_id      = room_q;
  assign wall_color   = wall_q;
  assign room_valid   = valid_q;
  assign player_load  = load_q;
  assign player_new_x = new_x_q;
  assign player_new_y = new_y_q;

endmodule

// File: tb/tb_room_controller.sv
// Directed bench for room_controller: room transitions, grid edges, priority and reset behaviour.
module tb_room_controller;

  logic       clk_vga = 1'b0;
  logic       rst_n, frame_start, player_valid;
  logic [9:0] player_x;
  logic [8:0] player_y;
  logic [3:0] room_id;
  logic [7:0] wall_color;
  logic       room_valid, player_load;
  logic [9:0] player_new_x;
  logic [8:0] player_new_y;

  int vectors = 0;
  int miscompares = 0;

  room_controller dut (
    .clk_vga      (clk_vga),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .player_valid (player_valid),
    .player_x     (player_x),
    .player_y     (player_y),
    .room_id      (room_id),
    .wall_color   (wall_color),
    .room_valid   (room_valid),
    .player_load  (player_load),
    .player_new_x (player_new_x),
    .player_new_y (player_new_y)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge with outputs settled.
  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk_vga);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk_vga);
    rst_n = 1'b1;
    @(negedge clk_vga);
  endtask

  task automatic exit_seq(input string tag, input logic [9:0] x, input logic [8:0] y,
                          input logic [3:0] old_room, input logic [3:0] new_room,
                          input logic [9:0] nx, input logic [8:0] ny);
    player_x = x;
    player_y = y;
    frame();
    check({tag, " blank_valid"}, 16'(room_valid), 16'd0);
    check({tag, " blank_room"}, 16'(room_id), 16'(old_room));
    player_x = 10'd300;
    player_y = 9'd111;
    frame();
    check({tag, " mid_load"}, 16'(player_load), 16'd0);
    frame();
    check({tag, " load"}, 16'(player_load), 16'd1);
    check({tag, " room"}, 16'(room_id), 16'(new_room));
    check({tag, " wall"}, 16'(wall_color), 16'({new_room, 4'b1100}));
    check({tag, " new_x"}, 16'(player_new_x), 16'(nx));
    check({tag, " new_y"}, 16'(player_new_y), 16'(ny));
    check({tag, " load_valid"}, 16'(room_valid), 16'd0);
    player_x = 10'd320;
    player_y = 9'd240;
    @(negedge clk_vga);
    check({tag, " play_load"}, 16'(player_load), 16'd0);
    check({tag, " play_valid"}, 16'(room_valid), 16'd1);
    check({tag, " hold_x"}, 16'(player_new_x), 16'(nx));
  endtask

  initial begin
    bit bad;
    rst_n = 1'b0;
    frame_start = 1'b0;
    player_valid = 1'b1;
    player_x = 10'd320;
    player_y = 9'd240;
    repeat (2) @(negedge clk_vga);
    check("rst room", 16'(room_id), 16'd5);
    check("rst wall", 16'(wall_color), 16'h5C);
    check("rst valid", 16'(room_valid), 16'd1);
    check("rst load", 16'(player_load), 16'd0);
    check("rst new_x", 16'(player_new_x), 16'd0);
    check("rst new_y", 16'(player_new_y), 16'd0);
    rst_n = 1'b1;
    @(negedge clk_vga);

    frame();
    check("center room", 16'(room_id), 16'd5);
    check("center valid", 16'(room_valid), 16'd1);
    check("center load", 16'(player_load), 16'd0);

    exit_seq("east", 10'd635, 9'd200, 4'd5, 4'd6, 10'd12, 9'd200);

    // Walk 6 -> 2 -> 1 -> 0 to reach the corner room.
    exit_seq("north", 10'd100, 9'd4, 4'd6, 4'd2, 10'd100, 9'd460);
    exit_seq("west1", 10'd4, 9'd100, 4'd2, 4'd1, 10'd620, 9'd100);
    exit_seq("west0", 10'd4, 9'd100, 4'd1, 4'd0, 10'd620, 9'd100);

    player_x = 10'd4;
    player_y = 9'd4;
    frame();
    check("corner valid", 16'(room_valid), 16'd1);
    frame();
    check("corner room", 16'(room_id), 16'd0);
    check("corner load", 16'(player_load), 16'd0);

    exit_seq("south", 10'd4, 9'd475, 4'd0, 4'd4, 10'd4, 9'd12);

    do_reset();
    check("rst2 room", 16'(room_id), 16'd5);
    exit_seq("prio", 10'd4, 9'd4, 4'd5, 4'd1, 10'd4, 9'd460);

    // Reset in the middle of blanking drops the pending move.
    do_reset();
    player_x = 10'd635;
    player_y = 9'd200;
    frame();
    check("abort blank", 16'(room_valid), 16'd0);
    player_x = 10'd320;
    player_y = 9'd240;
    do_reset();
    check("abort room", 16'(room_id), 16'd5);
    check("abort valid", 16'(room_valid), 16'd1);
    bad = 1'b0;
    repeat (3) begin
      frame();
      if (player_load || !room_valid || room_id != 4'd5) bad = 1'b1;
    end
    check("abort no_load", 16'(bad), 16'd0);

    player_valid = 1'b0;
    player_x = 10'd635;
    frame();
    check("pv0 valid", 16'(room_valid), 16'd1);
    frame();
    check("pv0 room", 16'(room_id), 16'd5);

    player_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk_vga);
      if (!room_valid || player_load || room_id != 4'd5) bad = 1'b1;
    end
    check("no_frame hold", 16'(bad), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/room_controller.md
ROOM_CONTROLLER -- requirements
Module: room_controller

Interface
REQ-001 Parameter START_ROOM, default 4'd5, room index loaded at reset.
REQ-002 Parameter BLANK_FRAMES, default 2, number of full frames the display is blanked during a room change (legal range 1-15).
REQ-003 Port clk_vga  input  1  pixel clock; sole clock for all state.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-006 Port player_valid  input  1  player_x/player_y are meaningful.
REQ-007 Port player_x  input  10  player pixel column, 0-639.
REQ-008 Port player_y  input  9  player pixel row, 0-479.
REQ-009 Port room_id  output  4  current room, {row[1:0], col[1:0]} of a 4x4 grid; selects the maze renderer.
REQ-010 Port wall_color  output  8  wall colour fed to the maze renderer.
REQ-011 Port room_valid  output  1  1 = render room; 0 = display blanked.
REQ-012 Port player_load  output  1  one-cycle pulse: player position must be replaced.
REQ-013 Port player_new_x  output  10  new player column, valid with player_load.
REQ-014 Port player_new_y  output  9  new player row, valid with player_load.

Function
REQ-015 State machine: PLAY, BLANK, LOAD; all outputs registered.
REQ-016 Exit detect (evaluated only in PLAY, on the frame_start cycle, with player_valid=1): north y<=8, south y>=471, west x<=8, east x>=631.
REQ-017 Exit taken only if the neighbour exists in the grid (no wrap); an exit off the grid edge is ignored.
REQ-018 Multiple valid exits in the same sample: priority north > south > west > east.
REQ-019 Valid exit: next cycle state=BLANK, room_valid=0, blank counter=0, room_id unchanged, pending direction latched.
REQ-020 BLANK: each frame_start increments the counter; the frame_start arriving when counter==BLANK_FRAMES-1 moves state to LOAD next cycle.
REQ-021 Entry to LOAD: room_id takes the neighbour index (north row-1, south row+1, west col-1, east col+1); player_load=1 for exactly that cycle.
REQ-022 New position: north y=460, x unchanged; south y=12, x unchanged; west x=620, y unchanged; east x=12, y unchanged (unchanged = value sampled at exit).
REQ-023 LOAD lasts one cycle, then PLAY with room_valid=1; frame_start during LOAD is ignored.
REQ-024 player_new_x/y hold their last values when player_load=0.
REQ-025 wall_color = {room_id, 4'b1100}, updated the same cycle as room_id.
REQ-026 player_valid, player_x and player_y are ignored outside PLAY.
REQ-027 No frame_start: state and outputs hold indefinitely.

Reset
REQ-028 rst_n low: state=PLAY, room_id=START_ROOM, wall_color={START_ROOM,4'b1100}, room_valid=1, player_load=0, player_new_x=0, player_new_y=0, counter=0, pending direction cleared.
REQ-029 Reset asserted mid-BLANK or LOAD discards the pending transition; no player_load pulse follows release.
REQ-030 First frame_start after reset release is evaluated normally.

Verification
REQ-031 Reset, frame_start with x=320,y=240 -> room_id=5, room_valid=1, no player_load.
REQ-032 Room 5, x=635,y=200, frame_start -> room_valid=0 next cycle; after 2 further frame_starts: room_id=6, wall_color=8'h6C, player_load 1 cycle, new_x=12, new_y=200, then room_valid=1.
REQ-033 Room 0, x=4,y=4, frame_start -> no transition (north/west off-grid); room 0, x=4,y=475 -> south taken, room_id=4, new_y=12.
REQ-034 Room 5, x=4,y=4 (north+west) -> room_id=1, new_y=460, new_x=4.
REQ-035 Exit sampled, rst_n pulsed low during BLANK -> room_id=5, room_valid=1, no player_load afterwards.
REQ-036 player_valid=0 at x=635 with frame_start -> no transition; exit position without frame_start for 10000 cycles -> no transition.
